// File: rtl/tff_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tff_count_ctrl
// Brief    : Bank of T flip-flops driven as an up/down counter by a four-state
//            controller (IDLE -> CLEAR -> RUN -> DONE) with a captured limit.
// Revision : 1.0 - initial release
// ============================================================================
module tff_count_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] bank_q, bank_d;
    logic [WIDTH-1:0] count_vec;
    logic             carry;

    // Ripple toggle pattern: bit i toggles when all lower bits are 1 (up)
    // or all lower bits are 0 (down).
    always_comb begin
        count_vec = '0;
        carry     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            count_vec[i] = carry;
            carry        = carry & (mode_q ? ~bank_q[i] : bank_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        t_vec   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    limit_d = limit;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_vec   = mode_q ? ~bank_q : bank_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (bank_q == limit_q) begin
                    state_d = S_DONE;
                end else begin
                    t_vec = count_vec;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bank_d = bank_q ^ t_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            limit_q <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
            bank_q  <= bank_d;
        end
    end

    assign q    = bank_q;
    assign qbar = ~bank_q;
    assign busy = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_tff_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_count_ctrl
// Brief    : Directed and randomized bench for tff_count_ctrl against an
//            arithmetic reference model of the counting sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tff_count_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] limit = 8'h00;
    logic [7:0] t_vec, q, qbar;
    logic       busy, done;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    tff_count_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .limit (limit),
        .t_vec (t_vec),
        .q     (q),
        .qbar  (qbar),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Model phases: 0 idle, 1 clear, 2 run, 3 done.
    int         m_ph = 0;
    logic [7:0] m_q = 8'h00;
    logic       m_mode = 1'b0;
    logic [7:0] m_lim = 8'h00;

    // Toggle vector = current value XOR the value the sequence moves to.
    function automatic logic [7:0] f_tvec(input int ph, input logic [7:0] qv,
                                          input logic md, input logic [7:0] lm,
                                          input logic sp);
        logic [7:0] nxt;
        case (ph)
            1: return qv ^ (md ? 8'hFF : 8'h00);
            2: begin
                if (sp || qv == lm) return 8'h00;
                nxt = md ? qv - 8'd1 : qv + 8'd1;
                return qv ^ nxt;
            end
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ph   <= 0;
            m_q    <= 8'h00;
            m_mode <= 1'b0;
            m_lim  <= 8'h00;
        end else begin
            m_q <= m_q ^ f_tvec(m_ph, m_q, m_mode, m_lim, stop);
            case (m_ph)
                0: if (start) begin
                    m_ph   <= 1;
                    m_mode <= mode;
                    m_lim  <= limit;
                end
                1: m_ph <= 2;
                2: if (stop) m_ph <= 0;
                   else if (m_q == m_lim) m_ph <= 3;
                default: m_ph <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_q",     {24'd0, q},     {24'd0, m_q});
            chk("cmp_qbar",  {24'd0, qbar},  {24'd0, ~m_q});
            chk("cmp_busy",  {31'd0, busy},  {31'd0, (m_ph == 1 || m_ph == 2)});
            chk("cmp_done",  {31'd0, done},  {31'd0, (m_ph == 3)});
            chk("cmp_t_vec", {24'd0, t_vec}, {24'd0, f_tvec(m_ph, m_q, m_mode, m_lim, stop)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic md, input logic [7:0] lm);
        start = 1'b1;
        mode  = md;
        limit = lm;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_q(input logic [7:0] v, input int budget);
        int n = 0;
        while (q !== v && n < budget) begin
            cyc();
            n++;
        end
        if (q !== v) chk("wait_q_timeout", {24'd0, q}, {24'd0, v});
    endtask

    // Returns the edge index (start edge = 0) at which done is first seen.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (done !== 1'b1 && n < budget);
    endtask

    logic [7:0] up_q    [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5};
    logic       up_done [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       up_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int  n;
        bit  seen;
        cyc();
        cyc();
        cmp_en = 1'b1;
        chk("reset_q",    {24'd0, q},     32'h00);
        chk("reset_qbar", {24'd0, qbar},  32'hFF);
        chk("reset_busy", {31'd0, busy},  32'd0);
        chk("reset_done", {31'd0, done},  32'd0);
        chk("reset_tvec", {24'd0, t_vec}, 32'h00);
        reset = 1'b0;
        cyc();

        // Up count to 5
        launch(1'b0, 8'd5);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("up_q",    {24'd0, q},    {24'd0, up_q[k]});
            chk("up_done", {31'd0, done}, {31'd0, up_done[k]});
            chk("up_busy", {31'd0, busy}, {31'd0, up_busy[k]});
        end

        // Bring bank to 0x03, then down count to 0xFA
        launch(1'b0, 8'd3);
        wait_done(20, n);
        cyc();
        chk("pre_down_q", {24'd0, q}, 32'h03);
        launch(1'b1, 8'hFA);
        cyc();
        chk("down_clear_q", {24'd0, q}, 32'hFF);
        wait_done(20, n);
        chk("down_done_edge", n + 1, 32'd7);
        chk("down_final_q", {24'd0, q}, 32'hFA);
        cyc();

        // Abort at q=10, then a fresh start completes
        launch(1'b0, 8'd100);
        wait_q(8'd10, 50);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q",    {24'd0, q},    32'd10);
        seen = 1'b0;
        repeat (5) begin
            cyc();
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        chk("abort_hold_q",  {24'd0, q},    32'd10);
        launch(1'b0, 8'd2);
        wait_done(20, n);
        chk("restart_done_edge", n, 32'd4);
        chk("restart_q", {24'd0, q}, 32'd2);
        cyc();

        // Limit equal to cleared value: zero steps
        launch(1'b0, 8'd0);
        wait_done(20, n);
        chk("lim0_done_edge", n, 32'd2);
        cyc();

        // Limit 0xFF: 255 steps, no wrap
        launch(1'b0, 8'hFF);
        wait_done(400, n);
        chk("limFF_done_edge", n, 32'd257);
        chk("limFF_q", {24'd0, q}, 32'hFF);
        cyc();

        // Stop coincident with match
        launch(1'b0, 8'd3);
        repeat (4) cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stopmatch_busy", {31'd0, busy}, 32'd0);
        chk("stopmatch_done", {31'd0, done}, 32'd0);
        chk("stopmatch_q",    {24'd0, q},    32'd3);
        cyc();
        chk("stopmatch_done2", {31'd0, done}, 32'd0);

        // start/limit/mode changes while running and start during DONE
        launch(1'b0, 8'd6);
        repeat (3) cyc();
        start = 1'b1;
        limit = 8'd2;
        mode  = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(20, n);
        chk("ignore_done_edge", n + 4, 32'd8);
        chk("ignore_q", {24'd0, q}, 32'd6);
        start = 1'b1;
        cyc();
        start = 1'b0;
        mode  = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        cyc();
        chk("done_start_busy2", {31'd0, busy}, 32'd0);
        chk("done_start_q", {24'd0, q}, 32'd6);

        // Reset mid-RUN
        launch(1'b0, 8'hFF);
        wait_q(8'h40, 100);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_q",    {24'd0, q},     32'h00);
        chk("midrst_busy", {31'd0, busy},  32'd0);
        chk("midrst_tvec", {24'd0, t_vec}, 32'h00);
        cyc();

        // Randomized traffic against the model
        repeat (4000) begin
            start = ($urandom % 4) == 0;
            stop  = ($urandom % 16) == 0;
            mode  = $urandom % 2;
            limit = $urandom % 256;
            reset = ($urandom % 300) == 0;
            cyc();
        end
        start = 1'b0;
        stop  = 1'b0;
        reset = 1'b0;
        cyc();
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tff_count_ctrl.md
TFF_COUNT_CTRL -- requirements
Module: tff_count_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, width of the toggle-flip-flop bank and the count.
REQ-002 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on the clk rising edge only.
REQ-004 Port: start  input  1  request to begin a count sequence; accepted only in IDLE.
REQ-005 Port: stop  input  1  abort request; acted on only in RUN.
REQ-006 Port: mode  input  1  0 = count up, 1 = count down; sampled with start.
REQ-007 Port: limit  input  WIDTH  terminal count; sampled with start.
REQ-008 Port: t_vec  output  WIDTH  per-bit toggle enables applied to the bank this cycle.
REQ-009 Port: q  output  WIDTH  bank state.
REQ-010 Port: qbar  output  WIDTH  bitwise complement of q, at all times.
REQ-011 Port: busy  output  1  high in CLEAR and RUN.
REQ-012 Port: done  output  1  high only in DONE, for exactly one cycle per completed sequence.

Function
REQ-013 The bank SHALL be WIDTH T flip-flops: on each edge, q[i] inverts when t_vec[i]=1 and holds otherwise; no other write path exists except reset.
REQ-014 The FSM SHALL have four states: IDLE, CLEAR, RUN and DONE.
REQ-015 IDLE: t_vec=0; if start=1, capture mode and limit into internal registers and go to CLEAR; otherwise stay.
REQ-016 CLEAR (one cycle): t_vec=q for up mode (bank goes to all zeros) and t_vec=qbar for down mode (bank goes to all ones); next state is RUN.
REQ-017 RUN, count pattern when q != captured limit:
- up mode: t_vec[0]=1 and t_vec[i]=&q[i-1:0];
- down mode: t_vec[0]=1 and t_vec[i]=&qbar[i-1:0];
- state stays RUN.
REQ-018 RUN, match: when q == captured limit and stop=0, t_vec=0 and next state is DONE.
REQ-019 RUN, abort: stop=1 SHALL force t_vec=0 and next state IDLE, with q held and no done pulse; stop takes priority over a simultaneous match.
REQ-020 DONE: done=1, t_vec=0, and the next state is IDLE unconditionally.
REQ-021 The count SHALL wrap modulo 2^WIDTH (up from all ones to 0, down from 0 to all ones) until a match occurs.
REQ-022 If the captured limit equals the post-CLEAR value, DONE SHALL follow the first RUN cycle with zero count steps.
REQ-023 start outside IDLE, and stop outside RUN, SHALL be ignored.
REQ-024 mode and limit changes after capture SHALL have no effect on the running sequence.
REQ-025 busy and done SHALL be decoded from the state only (Moore outputs); t_vec SHALL be combinational from state, the captured registers and q.
REQ-026 Latency: with the start edge as edge 0 and N count steps, done SHALL be high in the cycle after edge N+2.

Reset
REQ-027 reset=1 SHALL, at the next edge, set the state to IDLE, q=0, qbar=all ones, busy=0, done=0, t_vec=0, and clear the captured mode and limit.
REQ-028 reset SHALL override start, stop and any state, including a reset asserted mid-RUN or during DONE.

Verification (WIDTH=8)
REQ-029 Up count: reset, then start with mode=0 and limit=5 -> q goes 0,1,2,3,4,5; done is a single-cycle pulse after edge 7; busy is high across edges 1-6; then IDLE with q=5 held.
REQ-030 Down count: bank at 0x03, start with mode=1 and limit=0xFA -> CLEAR gives q=0xFF, then 0xFE down to 0xFA; done after edge 7.
REQ-031 Abort: start with up mode and limit=100, then stop at q=10 -> IDLE next edge, q holds 10, done never asserts; a new start with limit=2 completes normally.
REQ-032 Boundaries: up mode with limit=0 -> done after edge 2 with zero steps; up mode with limit=0xFF -> 255 steps with no wrap; simultaneous stop and match -> IDLE and no done.
REQ-033 Ignored inputs and reset: start pulses during RUN and DONE, and limit changes during RUN, change nothing; reset mid-RUN at q=0x40 -> q=0, IDLE and busy=0 at the next edge.
